// File: rtl/popcount24_vecgen.sv
`default_nettype none
// ============================================================================
// Module      : popcount24_vecgen
// Description : Count-to-vector generator: emits a 24-bit word holding exactly
//               the requested number of ones, thermometer or LFSR-scrambled.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount24_vecgen #(
    parameter int         N      = 24,
    parameter int         CW     = 5,
    parameter logic [7:0] SEED   = 8'hA5,
    parameter int         STRIDE = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cnt_valid,
    output logic          cnt_ready,
    input  logic [CW-1:0] cnt_data,
    input  logic          scramble_en,
    output logic          vec_valid,
    input  logic          vec_ready,
    output logic [N-1:0]  vec_data,
    output logic          cnt_err
);

    localparam logic [1:0]    c_IDLE   = 2'd0;
    localparam logic [1:0]    c_FILL   = 2'd1;
    localparam logic [1:0]    c_OUT    = 2'd2;
    localparam logic [CW-1:0] c_N      = CW'(N);
    localparam logic [CW-1:0] c_STRIDE = CW'(STRIDE);
    localparam logic [CW-1:0] c_ONE    = CW'(1);
    localparam logic [CW:0]   c_N_WIDE = (CW+1)'(N);

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [7:0]    r_lfsr;
    logic [CW-1:0] r_placed;
    logic [CW-1:0] r_target;
    logic [CW-1:0] r_ptr;
    logic          r_mode;
    logic [N-1:0]  r_vec;
    logic          r_err;

    logic          w_accept;
    logic          w_over;
    logic [CW-1:0] w_target_in;
    logic [CW-1:0] w_start_ptr;
    logic [CW-1:0] w_placed_next;
    logic [CW-1:0] w_step;
    logic [CW:0]   w_ptr_sum;
    logic [CW-1:0] w_ptr_next;
    logic          w_lfsr_fb;

    always_comb begin
        w_accept      = cnt_valid && (r_state == c_IDLE);
        w_over        = cnt_data > c_N;
        w_target_in   = w_over ? c_N : cnt_data;
        // Low five LFSR bits fold 24..31 back onto 16..23 to stay in range
        w_start_ptr   = (r_lfsr[4:0] >= 5'd24) ? (r_lfsr[4:0] - 5'd8) : r_lfsr[4:0];
        w_placed_next = r_placed + c_ONE;
        w_step        = r_mode ? c_STRIDE : c_ONE;
        w_ptr_sum     = {1'b0, r_ptr} + {1'b0, w_step};
        w_ptr_next    = (w_ptr_sum >= c_N_WIDE) ? CW'(w_ptr_sum - c_N_WIDE) : CW'(w_ptr_sum);
        w_lfsr_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_target_in == '0) ? c_OUT : c_FILL;
                end
            end
            c_FILL: begin
                if (w_placed_next == r_target) begin
                    w_state_next = c_OUT;
                end
            end
            c_OUT: begin
                if (vec_ready) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr   <= SEED;
            r_placed <= '0;
            r_target <= '0;
            r_ptr    <= '0;
            r_mode   <= 1'b0;
            r_vec    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_accept && w_over;
            if (w_accept) begin
                r_target <= w_target_in;
                r_placed <= '0;
                r_mode   <= scramble_en;
                r_ptr    <= scramble_en ? w_start_ptr : '0;
                r_vec    <= '0;
                r_lfsr   <= {r_lfsr[6:0], w_lfsr_fb};
            end else if (r_state == c_FILL) begin
                r_vec[r_ptr] <= 1'b1;
                r_placed     <= w_placed_next;
                r_ptr        <= w_ptr_next;
            end
        end
    end

    assign cnt_ready = (r_state == c_IDLE);
    assign vec_valid = (r_state == c_OUT);
    assign vec_data  = r_vec;
    assign cnt_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_popcount24_vecgen.sv
`default_nettype none
// ============================================================================
// Module      : tb_popcount24_vecgen
// Description : Directed table plus randomized sweep against a placement model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_popcount24_vecgen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cnt_valid = 1'b0;
    logic        cnt_ready;
    logic [4:0]  cnt_data = '0;
    logic        scramble_en = 1'b0;
    logic        vec_valid;
    logic        vec_ready = 1'b0;
    logic [23:0] vec_data;
    logic        cnt_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    popcount24_vecgen #(
        .N(24), .CW(5), .SEED(8'hA5), .STRIDE(7)
    ) u_dut (
        .clk(clk), .rst(rst),
        .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .cnt_data(cnt_data),
        .scramble_en(scramble_en),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
        .cnt_err(cnt_err)
    );

    typedef struct {
        bit          do_rst;
        int          cnt;
        bit          scr;
        logic [23:0] vec;
        int          lat;
        int          errp;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Placement positions follow directly from start + k*stride mod 24
    function automatic logic [23:0] model_vec(input int tgt, input bit scr, input int start);
        logic [23:0] v;
        v = '0;
        for (int k = 0; k < tgt; k++) v[scr ? (start + 7 * k) % 24 : k] = 1'b1;
        return v;
    endfunction

    function automatic int start_of(input logic [7:0] l);
        int s;
        s = int'(l) % 32;
        if (s >= 24) s = s - 8;
        return s;
    endfunction

    // x^8+x^6+x^5+x^4+1, shifted left with feedback into bit 0
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cnt_valid = 1'b0; vec_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue(input int c, input bit scr, output int lat, output int errp);
        int guard;
        guard = 0;
        while (!cnt_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_req", {31'd0, cnt_ready}, 32'd1);
        cnt_valid = 1'b1; cnt_data = 5'(c); scramble_en = scr;
        @(posedge clk);
        @(negedge clk);
        cnt_valid = 1'b0;
        lat  = 1;
        errp = cnt_err ? 1 : 0;
        while (!vec_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (cnt_err) errp++;
        end
    endtask

    task automatic drain(input int bp);
        logic [23:0] held;
        held = vec_data;
        vec_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, vec_valid}, 32'd1);
            check("hold_data", {8'd0, vec_data}, {8'd0, held});
            check("hold_ready", {31'd0, cnt_ready}, 32'd0);
        end
        vec_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vec_ready = 1'b0;
        check("idle_after_hs", {30'd0, vec_valid, cnt_ready}, 32'd1);
    endtask

    initial begin
        int          lat, errp, cov_cnt;
        logic [7:0]  m_lfsr;
        logic [23:0] exp_v;
        bit          seen_scr[25];
        bit          seen_nz_start;

        tbl[0] = '{1'b1,  5, 1'b0, 24'h00001F,  6, 0};
        tbl[1] = '{1'b1,  4, 1'b1, 24'h081024,  5, 0};
        tbl[2] = '{1'b0,  2, 1'b1, 24'h020400,  3, 0};
        tbl[3] = '{1'b1,  0, 1'b0, 24'h000000,  1, 0};
        tbl[4] = '{1'b0, 30, 1'b0, 24'hFFFFFF, 25, 1};
        tbl[5] = '{1'b1, 24, 1'b1, 24'hFFFFFF, 25, 0};
        tbl[6] = '{1'b0,  1, 1'b0, 24'h000001,  2, 0};

        do_reset();
        check("rst_vec_data", {8'd0, vec_data}, 32'd0);
        check("rst_vec_valid", {31'd0, vec_valid}, 32'd0);
        check("rst_cnt_ready", {31'd0, cnt_ready}, 32'd1);
        check("rst_cnt_err", {31'd0, cnt_err}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].do_rst) do_reset();
            issue(tbl[i].cnt, tbl[i].scr, lat, errp);
            check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            check($sformatf("tbl%0d_vec", i), {8'd0, vec_data}, {8'd0, tbl[i].vec});
            check($sformatf("tbl%0d_err", i), 32'(errp), 32'(tbl[i].errp));
            drain(2);
        end

        // Back-pressure for 10 cycles while a new request waits upstream
        do_reset();
        issue(7, 1'b0, lat, errp);
        check("bp_lat", 32'(lat), 32'd8);
        check("bp_vec", {8'd0, vec_data}, 32'h00007F);
        cnt_valid = 1'b1; cnt_data = 5'd3; scramble_en = 1'b0;
        drain(10);
        cnt_valid = 1'b0;

        // Reset in the middle of a long fill
        do_reset();
        cnt_valid = 1'b1; cnt_data = 5'd20; scramble_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cnt_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_vec_data", {8'd0, vec_data}, 32'd0);
        check("midrst_vec_valid", {31'd0, vec_valid}, 32'd0);
        check("midrst_cnt_ready", {31'd0, cnt_ready}, 32'd1);
        issue(3, 1'b1, lat, errp);
        check("midrst_next_lat", 32'(lat), 32'd4);
        check("midrst_next_vec", {8'd0, vec_data}, 32'h081020);
        drain(0);

        // Randomized sweep tracked by the model
        do_reset();
        m_lfsr = 8'hA5;
        seen_nz_start = 1'b0;
        for (int i = 0; i < 25; i++) seen_scr[i] = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            int c;
            bit scr;
            c   = int'($urandom_range(0, 24));
            scr = 1'($urandom_range(0, 1));
            exp_v = model_vec(c, scr, start_of(m_lfsr));
            if (scr) begin
                seen_scr[c] = 1'b1;
                if (start_of(m_lfsr) != 0) seen_nz_start = 1'b1;
            end
            m_lfsr = lfsr_next(m_lfsr);
            issue(c, scr, lat, errp);
            check("rnd_lat", 32'(lat), 32'(c + 1));
            check("rnd_vec", {8'd0, vec_data}, {8'd0, exp_v});
            check("rnd_popcount", 32'($countones(vec_data)), 32'(c));
            check("rnd_err", 32'(errp), 32'd0);
            drain(int'($urandom_range(0, 3)));
        end
        cov_cnt = 0;
        for (int i = 0; i < 25; i++) if (seen_scr[i]) cov_cnt++;
        check("cov_scr_counts", 32'(cov_cnt), 32'd25);
        check("cov_nz_start", {31'd0, seen_nz_start}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/popcount24_vecgen.md
Name: popcount24_vecgen

Overview:
- Inverse of the popcount24 family: takes a count value (0..24) over a valid/ready handshake and emits a 24-bit vector containing exactly that many ones.
- Placement is either thermometer (from bit 0 upward) or LFSR-scrambled.
- Drives exhaustive and random-pattern characterisation of approximate popcount24 circuits (MAE/WCE/EP measurement). It also serves as a unary-code decoder for ternary-neuron test streams.
- Sequential: one bit is placed per cycle, with buffered output.

Parameters:
- N, 24, vector width; fixed at 24 for this block.
- CW, 5, count width.
- SEED, 8'hA5, LFSR reset value; must be nonzero.
- STRIDE, 7, scrambled-mode pointer step; must be coprime with N.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- cnt_valid  input  1  count request valid
- cnt_ready  output  1  block can accept a count
- cnt_data  input  CW  requested number of ones
- scramble_en  input  1  scrambled placement; sampled at accept
- vec_valid  output  1  vector valid
- vec_ready  input  1  consumer accepts vector
- vec_data  output  N  generated vector
- cnt_err  output  1  one-cycle pulse: request exceeded N and was clamped

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; vec_data=0, vec_valid=0, cnt_err=0, cnt_ready=1 after the edge.
  - lfsr=SEED; placed=0, target=0, ptr=0.
  - Reset mid-FILL or mid-OUT abandons the vector; no output handshake occurs.
- Accept: cnt_valid & cnt_ready in IDLE.
  - target = min(cnt_data, 24); cnt_err=1 in the next cycle iff cnt_data>24, otherwise 0.
  - vec_data cleared to 0; placed=0; mode latched from scramble_en.
  - Start pointer: thermometer mode ptr=0. Scrambled mode ptr=lfsr[4:0], with values 24..31 mapped to value-8 (16..23). Uses the lfsr value before its step.
  - lfsr steps once per accept only: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left, feedback into bit0.
  - Next state: FILL if target>0, else OUT.
- FILL: each cycle:
  - set vec_data[ptr]; placed=placed+1.
  - ptr advances by 1 (thermometer) or STRIDE (scrambled), modulo 24 using a single conditional subtract.
  - When placed reaches target, next state is OUT.
  - A coprime stride guarantees no position repeats within 24 steps, so FILL lasts exactly target cycles.
- Latency: vec_valid first high exactly target+1 cycles after the accept edge (1 cycle for target=0, 25 cycles for 24).
- OUT:
  - vec_valid=1; vec_data held stable while vec_valid & !vec_ready.
  - On vec_valid & vec_ready: vec_valid=0 and state=IDLE next cycle.
  - No bypass: a new count cannot be accepted in the same cycle as the vector handshake.
- cnt_ready=1 only in IDLE; cnt_valid outside IDLE is ignored and must not be dropped by the source (standard handshake).
- Invariant: in OUT, popcount(vec_data)==target.
- Widths: placed, target and ptr are 5 bits; no state or counter may exceed 24.

Test Plan:
- Reset, then cnt_data=5, scramble_en=0 -> vec_valid exactly 6 cycles after accept; vec_data=24'h00001F; cnt_err=0.
- After reset (lfsr=8'hA5, start ptr=5), cnt_data=4, scramble_en=1 -> bits 5,12,19,2 set, vec_data=24'h081024, latency 5 cycles.
- cnt_data=0 -> vec_valid 1 cycle after accept with vec_data=0. Then cnt_data=30 -> cnt_err pulses once, vec_data=24'hFFFFFF, latency 25 cycles.
- Hold vec_ready=0 for 10 cycles in OUT -> vec_valid and vec_data stable, cnt_ready=0 throughout; release vec_ready -> IDLE next cycle, cnt_ready=1.
- Assert rst during FILL of cnt_data=20 -> next cycle vec_data=0, vec_valid=0, cnt_ready=1, lfsr=8'hA5; a following request for 3 behaves as if fresh from reset.
- Random sweep of 2000 requests, counts 0..24, random scramble_en and vec_ready back-pressure -> popcount(vec_data)==target on every output handshake. In scrambled mode, all 25 counts plus nonzero start pointers are observed.
